result_bram_scheduler: RTL and testbench
========================================

// Module: result_bram_scheduler
// PURPOSE
//  Sequences the shared result BRAMs (count_b1, count_b2, word_report) between the CA compute stream and the UART dump.
//  One run: COMPUTE phase streams input BRAM addresses and write-enables the result BRAMs.
//  DUMP phase then reads every written address and transmits an 8-byte framed record per address to uart_state_machine.
//  Owns the address mux and the enable/we strobes; no other block drives the result BRAM address.
// PARAMETERS
//  ADDR_W   8      result/input BRAM address width
//  RUN_LEN  256    addresses per run, 1..2**ADDR_W
//  HDR0     8'h55  frame byte 0; HDR1 8'h5A byte 2; HDR2 8'h5F byte 4; HDR3 8'h6F byte 6
// PORTS
//  CLK         in   1       system clock, 100 MHz; all logic on posedge
//  CPU_RESETN  in   1       asynchronous, active-low reset
//  run_req     in   1       1-cycle pulse: start a run; ignored unless state==IDLE
//  tx_busy     in   1       from uart_state_machine (baud domain); 2-flop synchronised internally
//  rd_b1/rd_b2/rd_w in 8    result BRAM read data, valid 1 CLK after bram_en with we=0
//  comp_en     out  1       input BRAM enable + CA stream valid
//  bram_addr   out  ADDR_W  shared address: input BRAM and result BRAMs
//  bram_en     out  1       result BRAM enable
//  bram_we     out  1       result BRAM write enable (COMPUTE only)
//  uart_start  out  1       level request to UART; held until synced tx_busy seen high
//  uart_data   out  8       byte to send; stable while uart_start=1 and until busy drops
//  busy        out  1       state!=IDLE
//  done        out  1       1-cycle pulse when the last dump byte has completed
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, counters 0; async assert, sync deassert on CLK.
//  States: IDLE -> COMPUTE -> DRAIN -> RD_ADDR -> RD_WAIT -> SEND -> ACK -> GAP -> (SEND | RD_ADDR | IDLE).
//  IDLE: run_req=1 -> COMPUTE, addr=0.
//  COMPUTE: comp_en=bram_en=bram_we=1 every cycle; addr increments 0..RUN_LEN-1; at RUN_LEN-1 -> DRAIN.
//  DRAIN: one cycle, all strobes 0 (covers CA/report register latency); addr:=0, byte_idx:=0 -> RD_ADDR.
//  RD_ADDR: bram_en=1, we=0 for one cycle -> RD_WAIT; RD_WAIT: latch rd_b1/rd_b2/rd_w into hold regs -> SEND.
//  Frame byte_idx 0..7: HDR0,b1,HDR1,b2,HDR2,w,HDR3,w (from hold regs; BRAMs not re-read).
//  SEND: uart_data=frame[byte_idx], uart_start=1; when busy_s=1 -> ACK (uart_start:=0 same edge).
//  ACK: wait busy_s=0 -> GAP. GAP (1 cycle): byte_idx<7 -> byte_idx+1, SEND;
//   byte_idx==7 and addr<RUN_LEN-1 -> addr+1, byte_idx:=0, RD_ADDR; else done=1, -> IDLE.
//  uart_data changes only in GAP/RD_WAIT, never while uart_start=1 or busy_s=1.
//  Address counter ADDR_W bits; RUN_LEN==2**ADDR_W terminates on compare, wraps to 0 without extra write.
//  run_req while busy: ignored, no queueing. run_req and done same cycle: ignored (state not yet IDLE).
//  tx_busy stuck high in SEND at entry (previous byte still running): SEND waits; start still held.
//  Reset mid-run: immediate abort, strobes drop asynchronously; partial BRAM contents undefined.
//  bram_we=1 only in COMPUTE; uart_start=1 only in SEND.
// TESTING
//  Reset with uart_start/comp_en high mid-run -> all outputs 0 at once, state IDLE, next run_req restarts addr 0.
//  RUN_LEN=4, run_req -> comp_en/bram_we high exactly 4 cycles, addr 0,1,2,3, then 1 DRAIN cycle all 0.
//  BRAM model addr k: b1=k, b2=k+1, w=8'hA0+k; UART model busy 3..20 cycles -> byte stream
//   55,00,5A,01,5F,A0,6F,A0,55,01,5A,02,... 32 bytes total, done pulses once after 32nd busy fall.
//  Hold tx_busy=1 for 100 cycles after start -> uart_start drops on first busy_s=1, uart_data constant throughout.
//  run_req pulses during COMPUTE and DUMP -> no restart, addr sequence unchanged; busy stays 1.
//  RUN_LEN=256, ADDR_W=8 -> 256 writes, 2048 bytes, addr ends at 255 with no write to wrapped address 0.

Source files
------------

// File: rtl/result_bram_scheduler.sv
// Result BRAM scheduler: sequences the shared result BRAMs between the CA compute
// stream (write pass) and the UART dump (read pass, 8-byte framed record per address).
module result_bram_scheduler #(
   parameter int         ADDR_W  = 8,
   parameter int         RUN_LEN = 256,
   parameter logic [7:0] HDR0    = 8'h55,
   parameter logic [7:0] HDR1    = 8'h5A,
   parameter logic [7:0] HDR2    = 8'h5F,
   parameter logic [7:0] HDR3    = 8'h6F
) (
   input  logic              CLK,
   input  logic              CPU_RESETN,
   input  logic              run_req,
   input  logic              tx_busy,
   input  logic [7:0]        rd_b1,
   input  logic [7:0]        rd_b2,
   input  logic [7:0]        rd_w,
   output logic              comp_en,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              bram_en,
   output logic              bram_we,
   output logic              uart_start,
   output logic [7:0]        uart_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RUN_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, COMPUTE, DRAIN, RD_ADDR, RD_WAIT, SEND, ACK, GAP
   } state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic [2:0]        byte_idx, byte_idx_nx;
   logic [7:0]        data_q, data_nx;
   logic [7:0]        h_b1, h_b2, h_w;
   logic              hold_ld;
   logic [1:0]        rst_sync;
   logic              rst_n;
   logic [1:0]        busy_sync;
   logic              busy_s;

   // Assert immediately, release only on a clock edge.
   always_ff @(posedge CLK or negedge CPU_RESETN) begin
      if (!CPU_RESETN) rst_sync <= 2'b00;
      else             rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // tx_busy comes from the baud domain.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) busy_sync <= 2'b00;
      else        busy_sync <= {busy_sync[0], tx_busy};
   end
   assign busy_s = busy_sync[1];

   function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] w);
      case (idx)
         3'd0:    return HDR0;
         3'd1:    return b1;
         3'd2:    return HDR1;
         3'd3:    return b2;
         3'd4:    return HDR2;
         3'd6:    return HDR3;
         default: return w;
      endcase
   endfunction

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr     <= '0;
         byte_idx <= '0;
         data_q   <= '0;
         h_b1     <= '0;
         h_b2     <= '0;
         h_w      <= '0;
      end else begin
         state    <= state_nx;
         addr     <= addr_nx;
         byte_idx <= byte_idx_nx;
         data_q   <= data_nx;
         if (hold_ld) begin
            h_b1 <= rd_b1;
            h_b2 <= rd_b2;
            h_w  <= rd_w;
         end
      end
   end

   // Strobes decode straight from state so a reset drops them without waiting for a clock.
   always_comb begin
      state_nx    = state;
      addr_nx     = addr;
      byte_idx_nx = byte_idx;
      data_nx     = data_q;
      hold_ld     = 1'b0;
      comp_en     = 1'b0;
      bram_en     = 1'b0;
      bram_we     = 1'b0;
      uart_start  = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (run_req) begin
               state_nx = COMPUTE;
               addr_nx  = '0;
            end
         end
         COMPUTE: begin
            comp_en = 1'b1;
            bram_en = 1'b1;
            bram_we = 1'b1;
            // Stop on compare so a full 2**ADDR_W run never writes the wrapped address.
            if (addr == LAST) state_nx = DRAIN;
            else              addr_nx  = addr + 1'b1;
         end
         DRAIN: begin
            addr_nx     = '0;
            byte_idx_nx = '0;
            state_nx    = RD_ADDR;
         end
         RD_ADDR: begin
            bram_en  = 1'b1;
            state_nx = RD_WAIT;
         end
         RD_WAIT: begin
            hold_ld  = 1'b1;
            data_nx  = HDR0;
            state_nx = SEND;
         end
         SEND: begin
            uart_start = 1'b1;
            if (busy_s) state_nx = ACK;
         end
         ACK: begin
            if (!busy_s) state_nx = GAP;
         end
         GAP: begin
            if (byte_idx != 3'd7) begin
               byte_idx_nx = byte_idx + 3'd1;
               data_nx     = frame_byte(byte_idx + 3'd1, h_b1, h_b2, h_w);
               state_nx    = SEND;
            end else if (addr != LAST) begin
               addr_nx     = addr + 1'b1;
               byte_idx_nx = '0;
               state_nx    = RD_ADDR;
            end else begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bram_addr = addr;
   assign uart_data = data_q;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_result_bram_scheduler.sv
// Randomized bench for result_bram_scheduler: BRAM and UART behavioural models,
// expected write/byte streams computed from the frame rules.
module tb_result_bram_scheduler;
   localparam int ADDR_W  = 2;
   localparam int RUN_LEN = 4;

   logic              CLK = 1'b0;
   logic              CPU_RESETN = 1'b0;
   logic              run_req = 1'b0;
   logic              tx_busy = 1'b0;
   logic [7:0]        rd_b1 = '0, rd_b2 = '0, rd_w = '0;
   logic              comp_en, bram_en, bram_we, uart_start, busy, done;
   logic [ADDR_W-1:0] bram_addr;
   logic [7:0]        uart_data;

   int checks = 0, errors = 0;
   logic [7:0] byte_q[$];
   int         wr_q[$];
   int         done_cnt, stab_err, hold_err, ovl_max, strobe_err;
   bit         long_first = 1'b0;
   bit         prev_we = 1'b0;

   result_bram_scheduler #(.ADDR_W(ADDR_W), .RUN_LEN(RUN_LEN)) dut (
      .CLK(CLK), .CPU_RESETN(CPU_RESETN), .run_req(run_req), .tx_busy(tx_busy),
      .rd_b1(rd_b1), .rd_b2(rd_b2), .rd_w(rd_w), .comp_en(comp_en),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .uart_start(uart_start), .uart_data(uart_data), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int k, input int i);
      case (i)
         0:       return 8'h55;
         1:       return 8'(k);
         2:       return 8'h5A;
         3:       return 8'(k + 1);
         4:       return 8'h5F;
         6:       return 8'h6F;
         default: return 8'(8'hA0 + k);
      endcase
   endfunction

   // Result BRAM contents for address k: b1=k, b2=k+1, w=A0+k; one-cycle read latency.
   always @(posedge CLK) begin
      if (bram_en && !bram_we) begin
         rd_b1 <= 8'(bram_addr);
         rd_b2 <= 8'(bram_addr) + 8'd1;
         rd_w  <= 8'hA0 + 8'(bram_addr);
      end
   end

   // UART: accept a start, answer after 0..2 cycles, stay busy 3..20 cycles (or 100).
   initial begin : uart_model
      logic [7:0] b;
      int ovl, hold;
      forever begin
         @(negedge CLK);
         if (uart_start && !tx_busy) begin
            b = uart_data;
            repeat ($urandom_range(0, 2)) begin
               @(negedge CLK);
               if (!uart_start || uart_data !== b) hold_err++;
            end
            tx_busy = 1'b1;
            hold = long_first ? 100 : int'($urandom_range(3, 20));
            long_first = 1'b0;
            ovl = 0;
            repeat (hold) begin
               @(negedge CLK);
               if (uart_data !== b) stab_err++;
               if (uart_start) ovl++;
            end
            if (ovl > ovl_max) ovl_max = ovl;
            tx_busy = 1'b0;
            byte_q.push_back(b);
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge CLK);
         if (bram_we) begin
            wr_q.push_back(int'(bram_addr));
            if (!(comp_en && bram_en)) strobe_err++;
         end
         if (prev_we && !bram_we && (comp_en || bram_en || uart_start)) strobe_err++;
         if (uart_start && (bram_en || comp_en)) strobe_err++;
         if (done) done_cnt++;
         prev_we = bram_we;
      end
   end

   task automatic chk_zero(input string tag);
      chk(tag, {comp_en, bram_en, bram_we, uart_start, busy, done, uart_data, 6'(bram_addr)}, 32'd0);
   endtask

   task automatic do_run(input string tag, input bit longh, input bit spam);
      int  busy_gap = 0;
      int  cyc = 0;
      bit  seen_done = 1'b0;
      int  n;
      byte_q.delete();
      wr_q.delete();
      done_cnt = 0; stab_err = 0; hold_err = 0; ovl_max = 0; strobe_err = 0;
      long_first = longh;
      @(negedge CLK); run_req = 1'b1;
      @(negedge CLK); run_req = 1'b0;
      while (!seen_done && cyc < 20000) begin
         @(negedge CLK);
         cyc++;
         if (!busy) busy_gap++;
         if (done) begin
            seen_done = 1'b1;
            if (spam) run_req = 1'b1;
         end else if (spam) begin
            run_req = ($urandom_range(0, 7) == 0);
         end
      end
      chk({tag, "_done_seen"}, seen_done, 1);
      @(negedge CLK); run_req = 1'b0;
      repeat (3) @(negedge CLK);
      chk({tag, "_idle_after"}, busy, 0);
      chk({tag, "_end_addr"}, bram_addr, RUN_LEN - 1);
      chk({tag, "_busy_gap"}, busy_gap, 0);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_nwr"}, wr_q.size(), RUN_LEN);
      n = (wr_q.size() < RUN_LEN) ? wr_q.size() : RUN_LEN;
      for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), wr_q[i], i);
      chk({tag, "_nbytes"}, byte_q.size(), 8 * RUN_LEN);
      n = (byte_q.size() < 8 * RUN_LEN) ? byte_q.size() : 8 * RUN_LEN;
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", tag, i), byte_q[i], exp_byte(i / 8, i % 8));
      chk({tag, "_data_stable"}, stab_err, 0);
      chk({tag, "_start_held"}, hold_err, 0);
      chk({tag, "_start_drop"}, ovl_max, 2);
      chk({tag, "_strobes"}, strobe_err, 0);
   endtask

   task automatic reset_mid(input string tag, input bit in_uart);
      int cyc = 0;
      @(negedge CLK); run_req = 1'b1;
      @(negedge CLK); run_req = 1'b0;
      while (!(in_uart ? uart_start : comp_en) && cyc < 2000) begin
         @(negedge CLK);
         cyc++;
      end
      chk({tag, "_reached"}, in_uart ? uart_start : comp_en, 1);
      #2 CPU_RESETN = 1'b0;
      #1 chk_zero({tag, "_async_zero"});
      @(negedge CLK); CPU_RESETN = 1'b1;
      cyc = 0;
      while (tx_busy && cyc < 200) begin
         @(negedge CLK);
         cyc++;
      end
      repeat (5) @(negedge CLK);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      #1 chk_zero("reset_state");
      repeat (3) @(negedge CLK);
      CPU_RESETN = 1'b1;
      repeat (3) @(negedge CLK);
      chk_zero("post_reset");
      do_run("basic", 1'b0, 1'b0);
      do_run("longhold", 1'b1, 1'b0);
      do_run("spam", 1'b0, 1'b1);
      reset_mid("rst_comp", 1'b0);
      do_run("after_rst_comp", 1'b0, 1'b0);
      reset_mid("rst_uart", 1'b1);
      do_run("after_rst_uart", 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
